ahb_lite_sram_slave: RTL and testbench

AHB-Lite subordinate (slave) that responds to the team's AHB-Lite Master: a word-organised register-array memory with byte, halfword and word access over a 32-bit data bus. It decodes the pipelined address/data phases and drives HRDATA, HREADYOUT and HRESP. It returns the two-cycle ERROR response for out-of-range, misaligned or unsupported accesses, so the Master's error path can be exercised against real RTL.

---
 rtl/ahb_lite_sram_slave_if.sv | 29 ++
 rtl/ahb_lite_sram_slave.sv | 156 +++++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between one Master and one SRAM subordinate.
// The HADDR width follows ADDR_W, and HREADY is the bus-level ready fed back to the subordinate.
interface ahb_lite_sram_slave_if #(
  parameter int ADDR_W = 32
);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic [1:0]        HTRANS;
  logic              HMASTLOCK;
  logic              HREADY;
  logic [31:0]       HWDATA;
  logic [31:0]       HRDATA;
  logic              HREADYOUT;
  logic              HRESP;

  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );

  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
    input  HREADY, HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM subordinate: word-organised register array with byte, halfword and word lanes, plus a two-cycle ERROR response.
// Define AHB_SLV_WAIT_EN to insert WAIT_CYCLES wait states before each OKAY data phase.
module ahb_lite_sram_slave #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahb_lite_sram_slave_if.slave  bus
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              LOW_W     = IDX_W + 2;
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(4 * DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_ERR1,
    S_ERR2
`ifdef AHB_SLV_WAIT_EN
    , S_WAIT
`endif
  } state_e;

  state_e           state_q;
  logic             hreadyout_q;
  logic             hresp_q;
  logic             write_q;
  logic [2:0]       size_q;
  logic [LOW_W-1:0] addr_q;
`ifdef AHB_SLV_WAIT_EN
  logic [3:0]       cnt_q;
`endif

  logic [31:0]      mem_q [DEPTH];
  logic             accept;
  logic             err_d;
  state_e           launch_d;
  logic [3:0]       be;
  logic             rd_phase;

  // A new address phase is only taken while this slave is not stalling the bus.
  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] & hreadyout_q;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    err_d = 1'b0;
    if ({1'b0, bus.HADDR} >= MEM_BYTES)               err_d = 1'b1;
    if (bus.HSIZE > 3'd2)                             err_d = 1'b1;
    if (bus.HSIZE == 3'd1 && bus.HADDR[0])            err_d = 1'b1;
    if (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00) err_d = 1'b1;
  end

  always_comb begin
    launch_d = S_DATA;
    if (err_d) begin
      launch_d = S_ERR1;
    end
`ifdef AHB_SLV_WAIT_EN
    else if (WAIT_CYCLES > 0) begin
      launch_d = S_WAIT;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      write_q     <= 1'b0;
      size_q      <= 3'd0;
      addr_q      <= '0;
`ifdef AHB_SLV_WAIT_EN
      cnt_q       <= 4'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DATA, S_ERR2: begin
          if (accept) begin
            state_q     <= launch_d;
            hreadyout_q <= (launch_d == S_DATA);
            hresp_q     <= (launch_d == S_ERR1);
            write_q     <= bus.HWRITE;
            size_q      <= bus.HSIZE;
            addr_q      <= bus.HADDR[LOW_W-1:0];
`ifdef AHB_SLV_WAIT_EN
            cnt_q       <= 4'(WAIT_CYCLES);
`endif
          end else begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
`ifdef AHB_SLV_WAIT_EN
        S_WAIT: begin
          if (cnt_q <= 4'd1) begin
            state_q     <= S_DATA;
            hreadyout_q <= 1'b1;
            cnt_q       <= 4'd0;
          end else begin
            cnt_q       <= cnt_q - 4'd1;
          end
        end
`endif
        S_ERR1: begin
          state_q     <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
        end
      endcase
    end
  end

  // Little-endian lane enables from the captured size and low address bits.
  always_comb begin
    be = 4'b0000;
    case (size_q)
      3'd0:    be[addr_q[1:0]] = 1'b1;
      3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // NOTE: the memory array has no reset; only control state is cleared.
  always_ff @(posedge HCLK) begin
    if (!HRESET && state_q == S_DATA && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[addr_q[LOW_W-1:2]][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end

`ifdef AHB_SLV_WAIT_EN
  assign rd_phase = !write_q && (state_q == S_DATA || state_q == S_WAIT);
`else
  assign rd_phase = !write_q && (state_q == S_DATA);
`endif

  assign bus.HRDATA    = rd_phase ? mem_q[addr_q[LOW_W-1:2]] : 32'd0;
  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;

  logic unused_ok;
  assign unused_ok = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0], 4'(WAIT_CYCLES)};

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for ahb_lite_sram_slave: OKAY and ERROR transfers, lane writes, back-to-back beats and mid-transfer reset.
// Expected wait states follow AHB_SLV_WAIT_EN (WAIT_CYCLES=2 when it is defined).
module tb_ahb_lite_sram_slave;

`ifdef AHB_SLV_WAIT_EN
  localparam int WAIT_EXP = 2;
`else
  localparam int WAIT_EXP = 0;
`endif
  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ahb_lite_sram_slave_if #(.ADDR_W(32)) bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_lite_sram_slave #(
    .ADDR_W(32),
    .DEPTH(256),
    .WAIT_CYCLES(2)
  ) dut (
    .HCLK(clk),
    .HRESET(rst),
    .bus(bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_addr(input logic [1:0] tr, input bit wr, input logic [31:0] a, input logic [2:0] sz);
    bus.HSEL   = 1'b1;
    bus.HTRANS = tr;
    bus.HWRITE = wr;
    bus.HADDR  = a;
    bus.HSIZE  = sz;
  endtask

  task automatic drive_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = T_IDLE;
    bus.HWRITE = 1'b0;
    bus.HADDR  = 32'd0;
    bus.HSIZE  = 3'd0;
  endtask

  // Entered just after a rising edge inside a data phase; leaves just after its completing edge.
  task automatic wait_done(input logic [31:0] exp_rd, input string tag);
    int waits = 0;
    @(negedge clk);
    while (!bus.HREADYOUT && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    check({tag, " waits"}, 32'(waits), 32'(WAIT_EXP));
    check({tag, " hresp"}, 32'(bus.HRESP), 32'd0);
    check({tag, " hrdata"}, bus.HRDATA, exp_rd);
    @(posedge clk); #1;
  endtask

  task automatic idle_okay(input string tag);
    @(negedge clk);
    check({tag, " hreadyout"}, 32'(bus.HREADYOUT), 32'd1);
    check({tag, " hresp"}, 32'(bus.HRESP), 32'd0);
    check({tag, " hrdata"}, bus.HRDATA, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic ok_xfer(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
    drive_addr(T_NONSEQ, wr, a, sz);
    @(posedge clk); #1;
    drive_idle();
    bus.HWDATA = wd;
    wait_done(exp_rd, tag);
  endtask

  task automatic err_xfer(input bit wr, input logic [31:0] a, input logic [2:0] sz, input string tag);
    drive_addr(T_NONSEQ, wr, a, sz);
    @(posedge clk); #1;
    drive_idle();
    bus.HWDATA = 32'hFFFF_FFFF;
    @(negedge clk);
    check({tag, " err1 ready"}, 32'(bus.HREADYOUT), 32'd0);
    check({tag, " err1 resp"}, 32'(bus.HRESP), 32'd1);
    check({tag, " err1 rdata"}, bus.HRDATA, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, " err2 ready"}, 32'(bus.HREADYOUT), 32'd1);
    check({tag, " err2 resp"}, 32'(bus.HRESP), 32'd1);
    @(posedge clk); #1;
    idle_okay({tag, " after"});
  endtask

  // Two word beats; optionally a BUSY cycle between them.
  task automatic b2b(input bit wr1, input logic [31:0] a1, input logic [31:0] d1,
                     input bit wr2, input logic [31:0] a2, input logic [31:0] d2,
                     input bit busy, input logic [31:0] rd1, input logic [31:0] rd2, input string tag);
    drive_addr(T_NONSEQ, wr1, a1, 3'd2);
    @(posedge clk); #1;
    bus.HWDATA = d1;
    if (busy) bus.HTRANS = T_BUSY;
    else      drive_addr(T_SEQ, wr2, a2, 3'd2);
    wait_done(rd1, {tag, "/1"});
    if (busy) begin
      drive_addr(T_SEQ, wr2, a2, 3'd2);
      idle_okay({tag, " busy"});
    end
    drive_idle();
    bus.HWDATA = d2;
    wait_done(rd2, {tag, "/2"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    drive_idle();
    bus.HBURST    = 3'd0;
    bus.HPROT     = 4'b0011;
    bus.HMASTLOCK = 1'b0;
    bus.HWDATA    = 32'd0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_okay("reset");

    // Write then read of the same word, back to back.
    b2b(1'b1, 32'h4, 32'hAABB_CCDD, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0, 32'hAABB_CCDD, "wr_rd_4");

    // Byte and halfword lane writes.
    ok_xfer(1'b1, 32'h5, 3'd0, 32'h0000_1100, 32'h0, "byte_5");
    ok_xfer(1'b1, 32'h6, 3'd1, 32'h2233_0000, 32'h0, "half_6");
    ok_xfer(1'b0, 32'h4, 3'd2, 32'h0, 32'h2233_11DD, "rd_4_lanes");

    // Out of range, then memory unchanged.
    err_xfer(1'b0, 32'h400, 3'd2, "oor_400");
    ok_xfer(1'b0, 32'h4, 3'd2, 32'h0, 32'h2233_11DD, "rd_4_after_err");

    // Misaligned and unsupported accesses write nothing.
    ok_xfer(1'b1, 32'h0, 3'd2, 32'hCAFE_F00D, 32'h0, "wr_0");
    err_xfer(1'b1, 32'h3, 3'd1, "half_mis_3");
    err_xfer(1'b1, 32'h2, 3'd2, "word_mis_2");
    err_xfer(1'b1, 32'h8000_0000, 3'd2, "high_bit");
    ok_xfer(1'b0, 32'h0, 3'd2, 32'h0, 32'hCAFE_F00D, "rd_0_intact");
    err_xfer(1'b0, 32'h8, 3'd3, "size3_8");

    // Last valid word.
    ok_xfer(1'b1, 32'h3FC, 3'd2, 32'h5A5A_A5A5, 32'h0, "wr_3fc");
    ok_xfer(1'b0, 32'h3FC, 3'd2, 32'h0, 32'h5A5A_A5A5, "rd_3fc");

    // Back-to-back writes with a BUSY in between, then back-to-back reads.
    b2b(1'b1, 32'h8, 32'h1, 1'b1, 32'hC, 32'h2, 1'b1, 32'h0, 32'h0, "wr_8_c");
    b2b(1'b0, 32'h8, 32'h0, 1'b0, 32'hC, 32'h0, 1'b0, 32'h1, 32'h2, "rd_8_c");

    // Reset during the first data-phase cycle of a write: write is dropped.
    ok_xfer(1'b1, 32'h10, 3'd2, 32'h1234_5678, 32'h0, "wr_10");
    drive_addr(T_NONSEQ, 1'b1, 32'h10, 3'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    drive_idle();
    bus.HWDATA = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_okay("rst_in_data");

    // Reset during ERR1.
    drive_addr(T_NONSEQ, 1'b0, 32'h400, 3'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    idle_okay("rst_in_err1");

    ok_xfer(1'b0, 32'h10, 3'd2, 32'h0, 32'h1234_5678, "rd_10_kept");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
